hilo_div_seq: RTL and testbench
===============================

HILO_DIV_SEQ -- requirements
Module: hilo_div_seq

Interface
REQ-001 SETTLE, default 2, number of wait cycles allowed for the combinational divider outputs to settle; legal range 1..15.
REQ-002 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 clear  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 BusMuxOut  in  32  shared operand bus; carries the dividend at the start edge and the divisor at the following edge.
REQ-006 Zhi_in  in  32  remainder from the external divider.
REQ-007 Zlo_in  in  32  quotient from the external divider.
REQ-008 D_out  out  32  registered dividend driven to the divider.
REQ-009 Q_out  out  32  registered divisor driven to the divider.
REQ-010 HI  out  32  remainder register.
REQ-011 LO  out  32  quotient register.
REQ-012 busy  out  1  high from the start edge until the WRITE edge.
REQ-013 done  out  1  one-cycle pulse after HI/LO update.
REQ-014 div_zero  out  1  sticky flag: last operation had a zero divisor.

Function
REQ-015 The FSM states SHALL be IDLE, LOAD_Q, WAIT, WRITE.
- IDLE: on start=1, D_out<=BusMuxOut, busy<=1, div_zero<=0, go to LOAD_Q; start=0 stays in IDLE.
- LOAD_Q: Q_out<=BusMuxOut, cnt<=SETTLE-1; go to WRITE if BusMuxOut==0, else to WAIT.
- WAIT: cnt==0 -> WRITE, else cnt<=cnt-1.
- WRITE: go to IDLE.
REQ-016 WRITE with nonzero divisor SHALL set HI<=Zhi_in, LO<=Zlo_in, and pass both through bit-exact (two's complement, truncating division; -2^31/-1 unmodified).
REQ-017 WRITE with zero divisor SHALL set HI<=D_out, LO<=32'hFFFFFFFF, div_zero<=1.
REQ-018 At the WRITE edge the block SHALL set done<=1 and busy<=0; done SHALL clear on the next edge.
REQ-019 Latency SHALL be fixed: with start accepted at edge 0, done is high after edge SETTLE+2 for a nonzero divisor and after edge 2 for a zero divisor.
REQ-020 start while busy=1 SHALL be ignored with no side effects.
REQ-021 start in the cycle where done=1 SHALL be accepted, since the FSM is then in IDLE.
REQ-022 HI, LO and div_zero SHALL hold their values between operations.
REQ-023 D_out and Q_out SHALL stay stable from their load edge through WRITE.

Reset
REQ-024 clear=1 at an edge SHALL force IDLE and zero D_out, Q_out, HI, LO, busy, done, div_zero and cnt, regardless of state.
REQ-025 clear SHALL take priority over start.
REQ-026 clear mid-operation SHALL abort the operation with no HI/LO update and no done pulse.

Structure
REQ-027 A shared package SHALL hold the state encoding (2-bit enum) and the constant DIVZ_LO = 32'hFFFFFFFF.
REQ-028 No sub-module is required: the divider is instantiated beside this block at datapath level, and the counter is inline.

Verification
REQ-029 The bench SHALL cover these scenarios (SETTLE=2):
- 6 then 3 -> LO=2, HI=0, div_zero=0, done after edge 4.
- 6 then -3 -> LO=32'hFFFFFFFE, HI=0.
- -7 then 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- 5 then 0 -> HI=5, LO=32'hFFFFFFFF, div_zero=1, done after edge 2.
- start pulsed again during WAIT -> ignored; a single done with the original result.
- clear asserted in WAIT after a prior result of HI=1, LO=4 -> all outputs 0 next cycle, no done, then a new 6/3 completes normally.

Source files
------------

// File: rtl/hilo_div_seq_pkg.sv
// Shared definitions for the HI/LO sequential divide controller.
// Holds the FSM state encoding and the divide-by-zero quotient constant.
// No logic; imported by the controller.
package hilo_div_seq_pkg;

    // Controller states: accept dividend, load divisor, let divider settle, commit result
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_Q = 2'd1,
        S_WAIT   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    // Quotient reported when the divisor is zero
    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

    // Settle counter width; covers SETTLE up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/hilo_div_seq.sv
// Sequences one divide through an external combinational divider into HI/LO.
// Latency: done high after edge SETTLE+2 (nonzero divisor) or edge 2 (zero divisor).
// No backpressure: start is sampled only in IDLE and ignored while busy.
module hilo_div_seq #(
    parameter int SETTLE = 2
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] BusMuxOut,
    input  logic [31:0] Zhi_in,
    input  logic [31:0] Zlo_in,
    output logic [31:0] D_out,
    output logic [31:0] Q_out,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    import hilo_div_seq_pkg::*;

    // Counter reload: WAIT spends SETTLE cycles before moving to WRITE
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic load_d;
    logic load_q;
    logic cnt_dec;
    logic write_res;
    logic divisor_zero;

    // Divisor is held in Q_out from LOAD_Q through WRITE, so it can be tested at WRITE
    assign divisor_zero = (Q_out == 32'd0);

    // State register; clear aborts any operation in flight
    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero divisor skips the settle wait entirely
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD_Q;
            S_LOAD_Q: state_nxt = (BusMuxOut == 32'd0) ? S_WRITE : S_WAIT;
            S_WAIT:   if (cnt == '0) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        load_d    = 1'b0;
        load_q    = 1'b0;
        cnt_dec   = 1'b0;
        write_res = 1'b0;
        case (state)
            S_IDLE:   load_d    = start;
            S_LOAD_Q: load_q    = 1'b1;
            S_WAIT:   cnt_dec   = (cnt != '0);
            S_WRITE:  write_res = 1'b1;
            default:  ;
        endcase
    end

    // Operand, counter, result and status registers
    always_ff @(posedge Clock) begin
        if (clear) begin
            D_out    <= '0;
            Q_out    <= '0;
            HI       <= '0;
            LO       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (load_d) begin
                D_out    <= BusMuxOut;
                busy     <= 1'b1;
                div_zero <= 1'b0;
            end
            if (load_q) begin
                Q_out <= BusMuxOut;
                cnt   <= CNT_INIT;
            end
            if (cnt_dec) begin
                cnt <= cnt - 1'b1;
            end
            if (write_res) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (divisor_zero) begin
                    // Divider output is meaningless here; report dividend as remainder
                    HI       <= D_out;
                    LO       <= DIVZ_LO;
                    div_zero <= 1'b1;
                end else begin
                    HI <= Zhi_in;
                    LO <= Zlo_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Bench for hilo_div_seq with a behavioural external divider.
module tb_hilo_div_seq;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        Clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] BusMuxOut;
    logic [31:0] Zhi_in;
    logic [31:0] Zlo_in;
    logic [31:0] D_out;
    logic [31:0] Q_out;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_zero;

    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    hilo_div_seq #(.SETTLE(2)) dut (
        .Clock     (Clock),
        .clear     (clear),
        .start     (start),
        .BusMuxOut (BusMuxOut),
        .Zhi_in    (Zhi_in),
        .Zlo_in    (Zlo_in),
        .D_out     (D_out),
        .Q_out     (Q_out),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 Clock = ~Clock;

    // External divider; drives junk on a zero divisor so passthrough would be caught
    always_comb begin
        if (Q_out == 32'd0) begin
            Zhi_in = 32'hDEAD_BEEF;
            Zlo_in = 32'h0BAD_F00D;
        end else begin
            Zlo_in = 32'($signed(D_out) / $signed(Q_out));
            Zhi_in = 32'($signed(D_out) % $signed(Q_out));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued result
    always @(negedge Clock) begin
        if (done === 1'b1) begin
            done_cnt++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("hi", HI, mon_e.hi);
                check("lo", LO, mon_e.lo);
                check("div_zero", 32'(div_zero), 32'(mon_e.dz));
            end
        end
    end

    // Called just after a negedge; returns at the negedge where done is seen (or after abort)
    task automatic run_op(input logic [31:0] dd, input logic [31:0] dv,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input int elat, input bit pulse, input bit abort);
        int k;
        bit seen;
        if (!abort) sb.push_back('{hi: ehi, lo: elo, dz: edz});
        start     = 1'b1;
        BusMuxOut = dd;
        @(posedge Clock); #1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("d_loaded", D_out, dd);
        @(negedge Clock);
        start     = 1'b0;
        BusMuxOut = dv;
        @(posedge Clock); #1;
        check("q_loaded", Q_out, dv);
        @(negedge Clock);
        BusMuxOut = 32'h1357_9BDF;
        k    = 1;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (abort && k == 2) begin
                clear = 1'b1;
                @(posedge Clock);
                @(negedge Clock);
                check("abort_d_out", D_out, 32'd0);
                check("abort_q_out", Q_out, 32'd0);
                check("abort_hi", HI, 32'd0);
                check("abort_lo", LO, 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_div_zero", 32'(div_zero), 32'd0);
                clear = 1'b0;
                return;
            end
            start = (pulse && k == 2);
            @(posedge Clock);
            k++;
            @(negedge Clock);
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        check("latency", 32'(k), 32'(elat));
        check("busy_at_done", 32'(busy), 32'd0);
        check("d_stable", D_out, dd);
        check("q_stable", Q_out, dv);
    endtask

    initial begin
        clear     = 1'b1;
        start     = 1'b0;
        BusMuxOut = 32'd0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_d_out", D_out, 32'd0);
        check("rst_q_out", Q_out, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        clear = 1'b0;
        @(negedge Clock);

        // Consecutive ops start in the done cycle of the previous one
        run_op(32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 4, 1'b0, 1'b0);
        run_op(32'd6, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFE, 1'b0, 4, 1'b0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 4, 1'b0, 1'b0);
        run_op(32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, 1'b0, 1'b0);

        // Results and sticky flag hold while idle
        repeat (3) @(negedge Clock);
        check("hold_hi", HI, 32'd5);
        check("hold_lo", LO, 32'hFFFF_FFFF);
        check("hold_div_zero", 32'(div_zero), 32'd1);
        check("hold_done", 32'(done), 32'd0);

        // Start pulsed during WAIT must not spawn a second operation
        run_op(32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 4, 1'b1, 1'b0);
        repeat (6) @(negedge Clock);
        check("single_done_count", 32'(done_cnt), 32'd5);
        check("idle_after_pulse", 32'(busy), 32'd0);

        // Abort in WAIT after a prior HI=1/LO=4 result, then a clean op
        run_op(32'd9, 32'd2, 32'd1, 32'd4, 1'b0, 4, 1'b0, 1'b0);
        @(negedge Clock);
        run_op(32'd6, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0, 1'b1);
        @(negedge Clock);
        run_op(32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 4, 1'b0, 1'b0);
        repeat (3) @(negedge Clock);
        check("final_done_count", 32'(done_cnt), 32'd7);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
